multiword_add_sequencer: RTL and testbench
==========================================

# multiword_add_sequencer

Sequences a single shared WIDTH-bit `ripple_carry_adder` (which has no carry-in) to add two NWORDS×WIDTH-bit operands, streamed least-significant word first, with the carry propagated between words. Each word uses two passes through the adder: term1+term2, then partial sum + stored carry. The block sits between an operand stream source and a result sink. It uses valid/ready handshakes on both sides and reports the final carry-out on completion.

## Interface
- WIDTH, 8, word width in bits (≥1)
- NWORDS, 4, words per operand (≥1)

- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  begin operation; honoured only in IDLE
- i_word_valid  in  1  operand word pair valid
- i_term1  in  WIDTH  operand A word
- i_term2  in  WIDTH  operand B word
- o_word_ready  out  1  operand word accepted when valid & ready
- o_sum_valid  out  1  result word valid
- o_sum  out  WIDTH  result word
- o_sum_last  out  1  result word is word NWORDS-1
- i_sum_ready  in  1  sink accepts result word
- o_carry_out  out  1  final carry; valid from o_done until next i_start
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle pulse after last result word is accepted

## Operation
- States: IDLE, LOAD, ADD, INC, OUT.
- IDLE: on i_start, clear carry_reg, idx and o_carry_out to 0, then go to LOAD. When not in IDLE, i_start is ignored.
- LOAD: o_word_ready=1. On i_word_valid, latch i_term1/i_term2 into a_reg/b_reg and go to ADD. i_word_valid is ignored in every other state.
- ADD: adder inputs are a_reg and b_reg. Latch partial <= result[WIDTH-1:0] and c1 <= result[WIDTH], then go to INC.
- INC: adder inputs are partial and the zero-extended carry_reg. Latch sum_reg <= result[WIDTH-1:0] and carry_reg <= c1 | result[WIDTH], then go to OUT. Both carries can never be 1 at once.
- OUT: o_sum_valid=1, o_sum=sum_reg, o_sum_last=(idx==NWORDS-1). Stay until i_sum_ready.
  - If o_sum_last: o_carry_out <= carry_reg, o_done pulses on the next cycle, go to IDLE.
  - Otherwise: idx <= idx+1, go to LOAD.
- The adder is purely combinational. Its input mux is selected by state (ADD vs INC), with zeros in all other states.
- idx width is max(1,$clog2(NWORDS)). NWORDS=1 goes straight from OUT to IDLE.
- Result words are produced in the same order as the input words (LS first), and each is sent exactly once.

## Timing
- Reset (async, immediate): state=IDLE; o_word_ready, o_sum_valid, o_sum, o_sum_last, o_carry_out, o_busy and o_done all 0; all internal registers 0.
- Reset mid-operation abandons the operation. No partial o_done is generated.
- A word accepted on the edge at the end of cycle T gives ADD in T+1, INC in T+2, and o_sum_valid=1 in T+3.
- Minimum 4 cycles per word. A full operation takes at least 1+4·NWORDS cycles from i_start to o_done.
- While o_sum_valid=1 and i_sum_ready=0, o_sum and o_sum_last hold stable and o_word_ready stays 0.
- o_done asserts exactly one cycle, in the cycle after the last handshake. o_busy is already 0 in that cycle.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Structure
- A shared package/include, `multiword_add_pkg`, holds the state encodings (S_IDLE, S_LOAD, S_ADD, S_INC, S_OUT) and the idx-width helper.
- Exactly one sub-module: `ripple_carry_adder` #(WIDTH), instantiated once.
- Sequencer, operand/partial/carry registers and the output register stay in this block.

## Test plan
- WIDTH=8, NWORDS=4: A words FF,00,00,00 and B words 01,00,00,00 → o_sum 00,01,00,00; o_carry_out=0; o_done pulses once.
- A=FF,FF,FF,FF and B=01,00,00,00 → o_sum 00,00,00,00 (carry rippling via INC); o_carry_out=1.
- NWORDS=2: A=FF,FF and B=01,FF → o_sum 00,FF (c1=1 in ADD, no INC overflow); o_carry_out=1.
- Word accepted at cycle T → o_sum_valid at T+3. Hold i_sum_ready=0 for 5 cycles → o_sum stable, o_word_ready=0, no new word taken. i_start pulsed during LOAD has no effect.
- Assert i_rst during INC of word 2 → all outputs 0 immediately, state IDLE. Then a new operation 01,00,00,00 + 01,00,00,00 → 02,00,00,00, with no leftover carry.
- NWORDS=1: FF+01 → o_sum=00, o_sum_last=1, o_carry_out=1, o_done the cycle after the handshake.

Source files
------------

// File: rtl/multiword_add_pkg.sv
// Shared definitions for the multi-word add sequencer: state encodings
// and the word-index width helper.
package multiword_add_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ADD  = 3'd2,
        S_INC  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // Word index width; a single-word operand still needs one index bit.
    function automatic int idx_width(input int nwords);
        if (nwords <= 1) begin
            return 1;
        end else begin
            return $clog2(nwords);
        end
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Purely combinational WIDTH-bit ripple-carry adder without carry-in.
// result[WIDTH] is the carry-out of the most significant bit.
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   result
);

    logic [WIDTH:0] carry_s;

    // Full-adder chain, carry rippling from bit 0 upward
    always_comb begin
        carry_s = '0;
        result  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            result[i]    = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
        result[WIDTH] = carry_s[WIDTH];
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds two NWORDS x WIDTH operands streamed LS word first, reusing one
// carry-in-less adder twice per word: a+b, then partial+carry.
module multiword_add_sequencer
    import multiword_add_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_word_valid,
    input  logic [WIDTH-1:0] i_term1,
    input  logic [WIDTH-1:0] i_term2,
    output logic             o_word_ready,
    output logic             o_sum_valid,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_sum_last,
    input  logic             i_sum_ready,
    output logic             o_carry_out,
    output logic             o_busy,
    output logic             o_done
);

    localparam int IDX_W = idx_width(NWORDS);

    state_t            state_r;
    state_t            state_nx_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  partial_r;
    logic [WIDTH-1:0]  sum_r;
    logic              c1_r;
    logic              carry_r;
    logic              carry_out_r;
    logic              done_r;
    logic [IDX_W-1:0]  idx_r;
    logic              last_s;
    logic [WIDTH-1:0]  add_a_s;
    logic [WIDTH-1:0]  add_b_s;
    logic [WIDTH:0]    add_res_s;

    assign last_s = (idx_r == IDX_W'(NWORDS - 1));

    // Adder input mux: operands in ADD, partial plus stored carry in INC
    always_comb begin
        add_a_s = '0;
        add_b_s = '0;
        case (state_r)
            S_ADD: begin
                add_a_s = a_r;
                add_b_s = b_r;
            end
            S_INC: begin
                add_a_s = partial_r;
                add_b_s = WIDTH'(carry_r);
            end
            default: begin
                add_a_s = '0;
                add_b_s = '0;
            end
        endcase
    end

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .a      (add_a_s),
        .b      (add_b_s),
        .result (add_res_s)
    );

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (i_start) state_nx_s = S_LOAD;
                else         state_nx_s = S_IDLE;
            end
            S_LOAD: begin
                if (i_word_valid) state_nx_s = S_ADD;
                else              state_nx_s = S_LOAD;
            end
            S_ADD:   state_nx_s = S_INC;
            S_INC:   state_nx_s = S_OUT;
            S_OUT: begin
                if (i_sum_ready) begin
                    if (last_s) state_nx_s = S_IDLE;
                    else        state_nx_s = S_LOAD;
                end else begin
                    state_nx_s = S_OUT;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_r <= S_IDLE;
        else       state_r <= state_nx_s;
    end

    // Operand, partial-sum, carry, index and result registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_r         <= '0;
            b_r         <= '0;
            partial_r   <= '0;
            sum_r       <= '0;
            c1_r        <= 1'b0;
            carry_r     <= 1'b0;
            carry_out_r <= 1'b0;
            done_r      <= 1'b0;
            idx_r       <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (i_start) begin
                        carry_r     <= 1'b0;
                        idx_r       <= '0;
                        carry_out_r <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (i_word_valid) begin
                        a_r <= i_term1;
                        b_r <= i_term2;
                    end
                end
                S_ADD: begin
                    partial_r <= add_res_s[WIDTH-1:0];
                    c1_r      <= add_res_s[WIDTH];
                end
                S_INC: begin
                    // a+b overflowing leaves partial <= 2^W-2, so the second
                    // pass cannot overflow as well; OR merges the two carries.
                    sum_r   <= add_res_s[WIDTH-1:0];
                    carry_r <= c1_r | add_res_s[WIDTH];
                end
                S_OUT: begin
                    if (i_sum_ready) begin
                        if (last_s) begin
                            carry_out_r <= carry_r;
                            done_r      <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_word_ready = (state_r == S_LOAD);
    assign o_sum_valid  = (state_r == S_OUT);
    assign o_sum        = sum_r;
    assign o_sum_last   = (state_r == S_OUT) && last_s;
    assign o_carry_out  = carry_out_r;
    assign o_busy       = (state_r != S_IDLE);
    assign o_done       = done_r;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer: three instances (NWORDS = 4,
// 2, 1) sharing clock and reset, a vector table of whole operations, and
// hand-written stall, ignored-start and mid-operation reset sequences.
module tb_multiword_add_sequencer;

    logic       clk;
    logic       rst;
    logic       start_s      [3];
    logic       word_valid_s [3];
    logic [7:0] term1_s      [3];
    logic [7:0] term2_s      [3];
    logic       word_ready_s [3];
    logic       sum_valid_s  [3];
    logic [7:0] sum_s        [3];
    logic       sum_last_s   [3];
    logic       sum_ready_s  [3];
    logic       carry_out_s  [3];
    logic       busy_s       [3];
    logic       done_s       [3];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NW = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
        multiword_add_sequencer #(.WIDTH(8), .NWORDS(NW)) dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_start      (start_s[g]),
            .i_word_valid (word_valid_s[g]),
            .i_term1      (term1_s[g]),
            .i_term2      (term2_s[g]),
            .o_word_ready (word_ready_s[g]),
            .o_sum_valid  (sum_valid_s[g]),
            .o_sum        (sum_s[g]),
            .o_sum_last   (sum_last_s[g]),
            .i_sum_ready  (sum_ready_s[g]),
            .o_carry_out  (carry_out_s[g]),
            .o_busy       (busy_s[g]),
            .o_done       (done_s[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [1:0]  d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        co;
    } vec_t;

    function automatic int nw_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed one word pair, check latency and result, optionally stall the sink.
    task automatic feed_word(input int d, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] exp_s, input logic exp_last, input int stall);
        int cnt = 0;
        while (word_ready_s[d] !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        chk("word_ready_wait", 32'(word_ready_s[d]), 32'd1);
        word_valid_s[d] = 1'b1;
        term1_s[d] = a;
        term2_s[d] = b;
        step();
        word_valid_s[d] = 1'b0;
        chk("add_no_sum_valid", 32'(sum_valid_s[d]), 32'd0);
        chk("add_no_word_ready", 32'(word_ready_s[d]), 32'd0);
        step();
        chk("inc_no_sum_valid", 32'(sum_valid_s[d]), 32'd0);
        step();
        chk("sum_valid_T3", 32'(sum_valid_s[d]), 32'd1);
        chk("sum_word", 32'(sum_s[d]), 32'(exp_s));
        chk("sum_last", 32'(sum_last_s[d]), 32'(exp_last));
        for (int i = 0; i < stall; i++) begin
            word_valid_s[d] = 1'b1;
            term1_s[d] = 8'hA5;
            term2_s[d] = 8'h5A;
            step();
            chk("stall_sum_valid", 32'(sum_valid_s[d]), 32'd1);
            chk("stall_sum", 32'(sum_s[d]), 32'(exp_s));
            chk("stall_last", 32'(sum_last_s[d]), 32'(exp_last));
            chk("stall_word_ready", 32'(word_ready_s[d]), 32'd0);
        end
        word_valid_s[d] = 1'b0;
        sum_ready_s[d] = 1'b1;
        step();
        sum_ready_s[d] = 1'b0;
    endtask

    task automatic pulse_start(input int d);
        start_s[d] = 1'b1;
        step();
        start_s[d] = 1'b0;
    endtask

    // Check the completion cycle right after the final handshake.
    task automatic check_done(input int d, input logic co);
        chk("done_pulse", 32'(done_s[d]), 32'd1);
        chk("done_busy_low", 32'(busy_s[d]), 32'd0);
        chk("carry_out", 32'(carry_out_s[d]), 32'(co));
        step();
        chk("done_single", 32'(done_s[d]), 32'd0);
        chk("carry_out_hold", 32'(carry_out_s[d]), 32'(co));
    endtask

    task automatic run_op(input vec_t v);
        int d;
        int nw;
        d  = int'(v.d);
        nw = nw_of(d);
        pulse_start(d);
        chk("busy_after_start", 32'(busy_s[d]), 32'd1);
        for (int w = 0; w < nw; w++) begin
            feed_word(d, v.a[8*w +: 8], v.b[8*w +: 8], v.s[8*w +: 8], (w == nw - 1), 0);
        end
        check_done(d, v.co);
    endtask

    task automatic check_all_zero(input string tag, input int d);
        chk({tag, "_word_ready"}, 32'(word_ready_s[d]), 32'd0);
        chk({tag, "_sum_valid"},  32'(sum_valid_s[d]),  32'd0);
        chk({tag, "_sum"},        32'(sum_s[d]),        32'd0);
        chk({tag, "_sum_last"},   32'(sum_last_s[d]),   32'd0);
        chk({tag, "_carry_out"},  32'(carry_out_s[d]),  32'd0);
        chk({tag, "_busy"},       32'(busy_s[d]),       32'd0);
        chk({tag, "_done"},       32'(done_s[d]),       32'd0);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{d: 2'd0, a: 32'h000000FF, b: 32'h00000001, s: 32'h00000100, co: 1'b0};
        vecs[1] = '{d: 2'd0, a: 32'hFFFFFFFF, b: 32'h00000001, s: 32'h00000000, co: 1'b1};
        vecs[2] = '{d: 2'd1, a: 32'h0000FFFF, b: 32'h0000FF01, s: 32'h0000FF00, co: 1'b1};
        vecs[3] = '{d: 2'd2, a: 32'h000000FF, b: 32'h00000001, s: 32'h00000000, co: 1'b1};
        vecs[4] = '{d: 2'd0, a: 32'h12345678, b: 32'h11111111, s: 32'h23456789, co: 1'b0};
        vecs[5] = '{d: 2'd0, a: 32'h80000000, b: 32'h80000000, s: 32'h00000000, co: 1'b1};
        vecs[6] = '{d: 2'd0, a: 32'h00FF00FF, b: 32'h00010001, s: 32'h01000100, co: 1'b0};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_s[i]      = 1'b0;
            word_valid_s[i] = 1'b0;
            term1_s[i]      = 8'h00;
            term2_s[i]      = 8'h00;
            sum_ready_s[i]  = 1'b0;
        end
        step();
        step();
        for (int i = 0; i < 3; i++) check_all_zero("reset", i);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i]);
            step();
        end

        // Sink stall on word 0 (which carries), then i_start pulsed in LOAD
        // must neither restart nor drop the pending carry.
        pulse_start(0);
        feed_word(0, 8'hFF, 8'h01, 8'h00, 1'b0, 5);
        chk("load_ready", 32'(word_ready_s[0]), 32'd1);
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        chk("start_ignored_busy", 32'(busy_s[0]), 32'd1);
        chk("start_ignored_ready", 32'(word_ready_s[0]), 32'd1);
        feed_word(0, 8'h00, 8'h00, 8'h01, 1'b0, 0);
        feed_word(0, 8'h00, 8'h00, 8'h00, 1'b0, 0);
        feed_word(0, 8'h00, 8'h00, 8'h00, 1'b1, 0);
        check_done(0, 1'b0);

        // Reset asserted during INC of word 2 with a carry pending.
        pulse_start(0);
        feed_word(0, 8'h01, 8'h01, 8'h02, 1'b0, 0);
        feed_word(0, 8'hF0, 8'h20, 8'h10, 1'b0, 0);
        chk("pre_rst_ready", 32'(word_ready_s[0]), 32'd1);
        word_valid_s[0] = 1'b1;
        term1_s[0] = 8'h33;
        term2_s[0] = 8'h44;
        step();
        word_valid_s[0] = 1'b0;
        step();
        chk("pre_rst_sum", 32'(sum_s[0]), 32'h10);
        rst = 1'b1;
        #1;
        check_all_zero("midrst", 0);
        step();
        rst = 1'b0;
        step();
        check_all_zero("post_rst", 0);
        step();
        chk("post_rst_no_done", 32'(done_s[0]), 32'd0);
        run_op('{d: 2'd0, a: 32'h00000001, b: 32'h00000001, s: 32'h00000002, co: 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
